// File: rtl/button_pkg.sv
// Shared constants for the push-button event FSM: state codes and
// default 27 MHz timing values.
package button_pkg;

   localparam int CNT_W_DEF         = 25;
   localparam int LONG_DELAY_DEF    = 13500000;  // 0.5 s at 27 MHz
   localparam int REPEAT_PERIOD_DEF = 2700000;   // 0.1 s at 27 MHz
   localparam int DC_WINDOW_DEF     = 8100000;   // 0.3 s at 27 MHz

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PRESSED = 3'd1,
      LONG    = 3'd2,
      WAIT_DC = 3'd3
   } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rise/fall detector for a slow, already-synchronous level.
// The previous-level register always loads the current input, so it also
// loads the current level during reset: a level held across reset yields
// no edge afterwards. No reset input is needed for that behaviour.
module edge_detect (
   input  logic clock,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic din_q;

   // Track the previous sampled level.
   always_ff @(posedge clock) begin
      din_q <= din;
   end

   assign rise = din & ~din_q;
   assign fall = ~din & din_q;

endmodule

// File: rtl/button_event_fsm.sv
// Push-button event FSM: turns a debounced level into one-cycle press,
// release, long-press and auto-repeat pulses, plus a held level.
// Optional double-click detection is compiled in with BUTTON_DOUBLE_CLICK_EN;
// without it double_click is tied low and the WAIT_DC state is absent.
module button_event_fsm
   import button_pkg::*;
#(
   parameter int LONG_DELAY    = LONG_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
   parameter int DC_WINDOW     = DC_WINDOW_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic clean,
   output logic press,
   output logic release_pulse,
   output logic long_press,
   output logic repeat_pulse,
   output logic held,
   output logic double_click
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] DC_LAST   = CNT_W'(DC_WINDOW - 1);

   logic             rise;
   logic             fall;
   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nx;
   logic             press_nx;
   logic             release_nx;
   logic             long_nx;
   logic             repeat_nx;
   logic             held_nx;
`ifdef BUTTON_DOUBLE_CLICK_EN
   logic             dc_nx;
`else
   logic             unused_dc;
   assign unused_dc    = ^DC_LAST;
   assign double_click = 1'b0;
`endif

   edge_detect u_edge (
      .clock (clock),
      .din   (clean),
      .rise  (rise),
      .fall  (fall)
   );

   // Next state, counter and pulse decode; a fall always beats a threshold.
   always_comb begin
      state_nx   = state;
      count_nx   = count + CNT_W'(1);
      press_nx   = 1'b0;
      release_nx = 1'b0;
      long_nx    = 1'b0;
      repeat_nx  = 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
      dc_nx      = 1'b0;
`endif
      case (state)
         IDLE: begin
            count_nx = '0;
            if (rise) begin
               press_nx = 1'b1;
               state_nx = PRESSED;
            end
         end
         PRESSED: begin
            if (fall) begin
               release_nx = 1'b1;
               count_nx   = '0;
`ifdef BUTTON_DOUBLE_CLICK_EN
               state_nx   = WAIT_DC;
`else
               state_nx   = IDLE;
`endif
            end else if (count == LONG_LAST) begin
               long_nx  = 1'b1;
               count_nx = '0;
               state_nx = LONG;
            end
         end
         LONG: begin
            if (fall) begin
               release_nx = 1'b1;
               count_nx   = '0;
               state_nx   = IDLE;
            end else if (count == REP_LAST) begin
               repeat_nx = 1'b1;
               count_nx  = '0;
            end
         end
`ifdef BUTTON_DOUBLE_CLICK_EN
         WAIT_DC: begin
            if (rise) begin
               press_nx = 1'b1;
               dc_nx    = 1'b1;
               count_nx = '0;
               state_nx = PRESSED;
            end else if (count == DC_LAST) begin
               count_nx = '0;
               state_nx = IDLE;
            end
         end
`endif
         default: begin
            count_nx = '0;
            state_nx = IDLE;
         end
      endcase
      held_nx = (state_nx == PRESSED) || (state_nx == LONG);
   end

   // State, counter and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         count         <= '0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
         repeat_pulse  <= 1'b0;
         held          <= 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
         double_click  <= 1'b0;
`endif
      end else begin
         state         <= state_nx;
         count         <= count_nx;
         press         <= press_nx;
         release_pulse <= release_nx;
         long_press    <= long_nx;
         repeat_pulse  <= repeat_nx;
         held          <= held_nx;
`ifdef BUTTON_DOUBLE_CLICK_EN
         double_click  <= dc_nx;
`endif
      end
   end

endmodule

// File: tb/tb_button_event_fsm.sv
// Directed bench for button_event_fsm with LONG_DELAY=20, REPEAT_PERIOD=5,
// DC_WINDOW=10. Inputs change 1 ns after a rising edge; outputs are
// sampled 1 ns after the rising edge that produced them.
module tb_button_event_fsm;

`ifdef BUTTON_DOUBLE_CLICK_EN
   localparam logic DC_EXP = 1'b1;
`else
   localparam logic DC_EXP = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic clean = 1'b0;
   logic press;
   logic release_pulse;
   logic long_press;
   logic repeat_pulse;
   logic held;
   logic double_click;

   int tests = 0;
   int fails = 0;

   button_event_fsm #(
      .LONG_DELAY    (20),
      .REPEAT_PERIOD (5),
      .DC_WINDOW     (10),
      .CNT_W         (25)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .clean         (clean),
      .press         (press),
      .release_pulse (release_pulse),
      .long_press    (long_press),
      .repeat_pulse  (repeat_pulse),
      .held          (held),
      .double_click  (double_click)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic p, input logic r,
                          input logic l, input logic rp, input logic h,
                          input logic dc);
      chk({tag, ".press"},   press,         p);
      chk({tag, ".release"}, release_pulse, r);
      chk({tag, ".long"},    long_press,    l);
      chk({tag, ".repeat"},  repeat_pulse,  rp);
      chk({tag, ".held"},    held,          h);
      chk({tag, ".dclick"},  double_click,  dc);
   endtask

   // n quiet cycles with the button released: every output must stay low.
   task automatic idle(input string tag, input int n);
      clean = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         chk_all($sformatf("%s_idle%0d", tag, i), 0, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      clean = 1'b0;
      tick();
      tick();
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      idle("start", 2);

      // Short press: 8 cycles high
      clean = 1'b1;
      tick();
      chk_all("sp_press", 1, 0, 0, 0, 1, 0);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk_all($sformatf("sp_hold%0d", k), 0, 0, 0, 0, 1, 0);
      end
      clean = 1'b0;
      tick();
      chk_all("sp_release", 0, 1, 0, 0, 0, 0);
      idle("sp", 12);

      // Long hold: 40 cycles high, fall lands on a repeat threshold
      clean = 1'b1;
      tick();
      chk_all("lh_press", 1, 0, 0, 0, 1, 0);
      for (int k = 1; k < 40; k++) begin
         tick();
         chk_all($sformatf("lh_k%0d", k), 0, 0, (k == 20),
                 (k == 25) || (k == 30) || (k == 35), 1, 0);
      end
      clean = 1'b0;
      tick();
      chk_all("lh_release", 0, 1, 0, 0, 0, 0);
      idle("lh", 12);

      // Threshold race: fall in the cycle the hold count reaches 19
      clean = 1'b1;
      tick();
      chk_all("tr_press", 1, 0, 0, 0, 1, 0);
      for (int k = 1; k < 20; k++) begin
         tick();
         chk_all($sformatf("tr_k%0d", k), 0, 0, 0, 0, 1, 0);
      end
      clean = 1'b0;
      tick();
      chk_all("tr_release", 0, 1, 0, 0, 0, 0);
      idle("tr", 12);

      // Reset while held
      clean = 1'b1;
      tick();
      chk_all("rh_press", 1, 0, 0, 0, 1, 0);
      tick();
      tick();
      chk_all("rh_hold", 0, 0, 0, 0, 1, 0);
      reset = 1'b1;
      tick();
      chk_all("rh_in_reset", 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all($sformatf("rh_after%0d", k), 0, 0, 0, 0, 0, 0);
      end
      clean = 1'b0;
      tick();
      chk_all("rh_fall", 0, 0, 0, 0, 0, 0);
      idle("rh", 12);

      // Double click: 4-cycle press, release, re-press 6 cycles later
      clean = 1'b1;
      tick();
      chk_all("dc_press1", 1, 0, 0, 0, 1, 0);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk_all($sformatf("dc_hold1_%0d", k), 0, 0, 0, 0, 1, 0);
      end
      clean = 1'b0;
      tick();
      chk_all("dc_release1", 0, 1, 0, 0, 0, 0);
      idle("dc_gap1", 5);
      clean = 1'b1;
      tick();
      chk_all("dc_press2", 1, 0, 0, 0, 1, DC_EXP);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk_all($sformatf("dc_hold2_%0d", k), 0, 0, 0, 0, 1, 0);
      end
      clean = 1'b0;
      tick();
      chk_all("dc_release2", 0, 1, 0, 0, 0, 0);
      // Re-press 12 cycles after release: window has closed
      idle("dc_gap2", 11);
      clean = 1'b1;
      tick();
      chk_all("dc_press3", 1, 0, 0, 0, 1, 0);
      tick();
      chk_all("dc_hold3", 0, 0, 0, 0, 1, 0);
      clean = 1'b0;
      tick();
      chk_all("dc_release3", 0, 1, 0, 0, 0, 0);
      idle("end", 12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
